// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle fetch/decode/execute control unit for a 16-bit datapath
// Define CU_ILLEGAL_TRAP_EN to halt with a sticky illegal flag on opcodes 0xE/0xF (default: NOP).
module control_unit #(
    parameter logic [3:0] OP_ADD   = 4'h0,
    parameter logic [3:0] OP_PASSB = 4'hF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [7:0]  imem_addr,
    input  logic [15:0] imem_data,
    input  logic        V,
    input  logic        C,
    input  logic        N,
    input  logic        Z,
    output logic        load_en,
    output logic        data_sel,
    output logic        const_sel,
    output logic [3:0]  A_sel,
    output logic [3:0]  B_sel,
    output logic [3:0]  dest_sel,
    output logic [3:0]  op_sel,
    output logic [15:0] const_in,
    output logic        dmem_re,
    output logic        dmem_we,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        HALT
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [3:0]  flags_q, flags_d;  // {V, C, N, Z}

    logic [3:0]  opcode, rd, ra, rb;
    logic [7:0]  imm8;
    logic        br_taken;
    logic        load_en_c, dmem_we_c;

    assign opcode = ir_q[15:12];
    assign rd     = ir_q[11:8];
    assign ra     = ir_q[7:4];
    assign rb     = ir_q[3:0];
    assign imm8   = ir_q[7:0];

    assign imem_addr = pc_q;
    assign halted    = (state_q == HALT);

`ifdef CU_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        br_taken = 1'b0;
        case (rd)
            4'd0:    br_taken = 1'b1;
            4'd1:    br_taken = flags_q[0];
            4'd2:    br_taken = ~flags_q[0];
            4'd3:    br_taken = flags_q[1];
            4'd4:    br_taken = flags_q[2];
            4'd5:    br_taken = flags_q[3];
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        flags_d = flags_q;
`ifdef CU_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH:  state_d = DECODE;
            DECODE: begin
                // Synchronous ROM: the word addressed during FETCH is valid now.
                ir_d    = imem_data;
                pc_d    = pc_q + 8'd1;
                state_d = EXEC;
            end
            EXEC: begin
                state_d = FETCH;
                case (opcode)
                    4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9:
                        flags_d = {V, C, N, Z};
                    4'hA: state_d = MEM;
                    4'hC: begin
                        // pc already points past the branch; 8-bit add wraps like the sign-extended offset.
                        if (br_taken) pc_d = pc_q + imm8;
                    end
                    4'hD: state_d = HALT;
                    4'hE, 4'hF: begin
`ifdef CU_ILLEGAL_TRAP_EN
                        state_d   = HALT;
                        illegal_d = 1'b1;
`endif
                    end
                    default: ;
                endcase
            end
            MEM:     state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= 8'd0;
            ir_q    <= 16'd0;
            flags_q <= 4'd0;
`ifdef CU_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
`ifdef CU_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    always_comb begin
        load_en_c = 1'b0;
        dmem_we_c = 1'b0;
        data_sel  = 1'b0;
        const_sel = 1'b0;
        A_sel     = 4'd0;
        B_sel     = 4'd0;
        dest_sel  = 4'd0;
        op_sel    = 4'd0;
        const_in  = 16'd0;
        dmem_re   = 1'b0;
        if (state_q == EXEC) begin
            case (opcode)
                4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                    op_sel    = {1'b0, opcode[2:0]};
                    A_sel     = ra;
                    B_sel     = rb;
                    dest_sel  = rd;
                    load_en_c = 1'b1;
                end
                4'h8: begin
                    dest_sel  = rd;
                    const_sel = 1'b1;
                    const_in  = {{8{imm8[7]}}, imm8};
                    op_sel    = OP_PASSB;
                    load_en_c = 1'b1;
                end
                4'h9: begin
                    dest_sel  = rd;
                    A_sel     = ra;
                    const_sel = 1'b1;
                    const_in  = {12'd0, rb};
                    op_sel    = OP_ADD;
                    load_en_c = 1'b1;
                end
                4'hA: begin
                    A_sel   = ra;
                    dmem_re = 1'b1;
                end
                4'hB: begin
                    A_sel     = ra;
                    B_sel     = rb;
                    dmem_we_c = 1'b1;
                end
                default: ;
            endcase
        end else if (state_q == MEM) begin
            A_sel     = ra;
            dest_sel  = rd;
            data_sel  = 1'b1;
            load_en_c = 1'b1;
        end
    end

    // Writes must not commit on an edge where reset is sampled.
    assign load_en = load_en_c & ~reset;
    assign dmem_we = dmem_we_c & ~reset;

endmodule
